aes_rcon_gen: RTL and testbench
===============================

# aes_rcon_gen

Sequential AES round-constant generator that replaces the fixed ten-constant table with an on-the-fly GF(2^8) xtime stepper. Serves the key-expansion engine: it loads on `start`, emits one constant per `next` pulse, and stops at the last constant required by the selected key length (AES-128/192/256). An optional reverse stepper supports decryption-side key schedules.

## Interface
- `POLY`, 8'h1B, low byte of the field reduction polynomial; bit 0 must be 1.
- `RC_INIT`, 8'h01, first round constant loaded on `start`.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  load `RC_INIT`, index 1, latch `key_len`.
- `key_len`  in  2  00 = AES-128 (10 constants), 01 = AES-192 (8), 10 = AES-256 (7), 11 = treated as 00.
- `next`  in  1  advance to the next constant.
- `prev`  in  1  step back one constant (only with `RCON_INVERSE_EN`; otherwise ignored).
- `rc_out`  out  8  current round constant.
- `rc_idx`  out  4  current constant index, 1..N.
- `valid`  out  1  `rc_out`/`rc_idx` are meaningful.
- `last`  out  1  `valid` and `rc_idx` == N for the latched key length.
- `done`  out  1  sequence exhausted; held until `start` or `rst`.

## Operation
- States: IDLE, RUN, DONE.
- Reset (any state, any cycle): IDLE; `rc_out`=8'h00, `rc_idx`=0, `valid`=0, `last`=0, `done`=0; latched length = 10.
- IDLE: `start` -> RUN, `rc_out`=`RC_INIT`, `rc_idx`=1, N latched from `key_len`. `next`/`prev` ignored.
- RUN, `next` and not `last`: `rc_out` <= xtime(`rc_out`) = {`rc_out`[6:0],0} ^ (`rc_out`[7] ? `POLY` : 0); `rc_idx`+1.
- RUN, `next` with `last`: -> DONE; `valid`=0, `done`=1; `rc_out`/`rc_idx` hold the final value.
- DONE: only `start` or `rst` leave; `next`/`prev` ignored.
- Priority: `rst` > `start` > `next`/`prev`. `start` in any state (including mid-RUN) restarts at index 1 and relatches `key_len`.
- `next` and `prev` asserted together: no change.
- `key_len` is sampled only on `start`; later changes have no effect.
- With default parameters the sequence is 01 02 04 08 10 20 40 80 1B 36 (index 8 = 8'h80).

## Timing
- `start` at edge k -> `valid`=1, `rc_out`=`RC_INIT` after edge k.
- `next`/`prev`: one-cycle latency; new value visible after the sampling edge. Back-to-back pulses advance one step per cycle.
- `last` is combinational from registered `rc_idx` and latched N; no extra latency.
- `done` rises the cycle after `next` is sampled with `last`=1.
- Outputs are registered except `last`.

## Configuration
- `RCON_INVERSE_EN` defined: `prev` in RUN with `rc_idx` > 1 applies inverse xtime: `rc_out`[0] ? ((`rc_out` ^ `POLY`) >> 1) | 8'h80 : `rc_out` >> 1; `rc_idx`-1. `prev` at `rc_idx`=1 is ignored. `prev` in DONE is ignored.
- Undefined: `prev` port is present but unused; no inverse logic is synthesised.

## Test plan
- Reset, then `start` with `key_len`=00 and 9 `next` pulses -> `rc_out` steps 01,02,04,08,10,20,40,80,1B,36; `last`=1 at index 10; a 10th `next` gives `done`=1, `valid`=0, and `rc_out` holds 36.
- `key_len`=10 -> `last` at index 7 (`rc_out`=40); `key_len`=01 -> `last` at index 8 (`rc_out`=80); `key_len`=11 behaves as 00.
- `start` asserted at index 5 together with `next` -> index 1, `rc_out`=01 (start wins); `rst` at index 6 -> all outputs 0, state IDLE next cycle.
- `next`+`prev` in the same cycle at index 3 -> `rc_out` stays 04; `next` in IDLE or DONE -> no change.
- With `RCON_INVERSE_EN`: advance to index 10 (36), then 9 `prev` pulses -> 1B,80,40,...,01; one more `prev` at index 1 -> holds 01.
- `POLY`=8'h1D, `RC_INIT`=8'h01, 9 `next` pulses -> index 9 = 1D, index 10 = 3A.

Source files
------------

// File: rtl/aes_rcon_gen.sv
// AES round-constant generator: GF(2^8) xtime stepper with per-key-length termination.
// Define RCON_INVERSE_EN to enable the reverse (inverse xtime) stepper driven by prev.
module aes_rcon_gen #(
   parameter logic [7:0] POLY    = 8'h1B,
   parameter logic [7:0] RC_INIT = 8'h01
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] key_len,
   input  logic       next,
   input  logic       prev,
   output logic [7:0] rc_out,
   output logic [3:0] rc_idx,
   output logic       valid,
   output logic       last,
   output logic       done
);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] rc_q, rc_d;
   logic [3:0] idx_q, idx_d;
   logic [3:0] len_q, len_d;
   logic       valid_q, valid_d;
   logic       done_q, done_d;
   logic       step_fwd;

   // Number of round constants consumed by each key length; 11 falls back to AES-128.
   function automatic logic [3:0] len_of(input logic [1:0] kl);
      logic [3:0] n;
      case (kl)
         2'b01:   n = 4'd8;
         2'b10:   n = 4'd7;
         default: n = 4'd10;
      endcase
      return n;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] v);
      return {v[6:0], 1'b0} ^ (v[7] ? POLY : 8'h00);
   endfunction

`ifdef RCON_INVERSE_EN
   logic step_bwd;

   // Exact inverse of xtime; relies on POLY[0] being 1 to identify the reduced case.
   function automatic logic [7:0] inv_xtime(input logic [7:0] v);
      return v[0] ? (((v ^ POLY) >> 1) | 8'h80) : (v >> 1);
   endfunction

   assign step_bwd = prev & ~next;
`else
   logic unused_prev;
   assign unused_prev = prev;
`endif

   assign step_fwd = next & ~prev;
   assign last     = valid_q && (idx_q == len_q);

   always_comb begin
      state_d = state_q;
      rc_d    = rc_q;
      idx_d   = idx_q;
      len_d   = len_q;
      valid_d = valid_q;
      done_d  = done_q;

      if (start) begin
         state_d = StRun;
         rc_d    = RC_INIT;
         idx_d   = 4'd1;
         len_d   = len_of(key_len);
         valid_d = 1'b1;
         done_d  = 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
            end
            StRun: begin
               if (step_fwd) begin
                  if (last) begin
                     state_d = StDone;
                     valid_d = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     rc_d  = xtime(rc_q);
                     idx_d = idx_q + 4'd1;
                  end
               end
`ifdef RCON_INVERSE_EN
               else if (step_bwd && (idx_q > 4'd1)) begin
                  rc_d  = inv_xtime(rc_q);
                  idx_d = idx_q - 4'd1;
               end
`endif
            end
            StDone: begin
            end
            default: begin
               state_d = StIdle;
               valid_d = 1'b0;
               done_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         rc_q    <= 8'h00;
         idx_q   <= 4'd0;
         len_q   <= 4'd10;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rc_q    <= rc_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   assign rc_out = rc_q;
   assign rc_idx = idx_q;
   assign valid  = valid_q;
   assign done   = done_q;

endmodule

// File: tb/tb_aes_rcon_gen.sv
// Scoreboard bench for aes_rcon_gen: two instances (POLY 1B and 1D) driven in lockstep.
module tb_aes_rcon_gen;

   logic       clk = 1'b0;
   logic       rst, start, next, prev;
   logic [1:0] key_len;
   logic [7:0] rc_a, rc_b;
   logic [3:0] idx_a, idx_b;
   logic       valid_a, valid_b, last_a, last_b, done_a, done_b;

   always #5 clk = ~clk;

   aes_rcon_gen dut_a (
      .clk(clk), .rst(rst), .start(start), .key_len(key_len), .next(next), .prev(prev),
      .rc_out(rc_a), .rc_idx(idx_a), .valid(valid_a), .last(last_a), .done(done_a)
   );

   aes_rcon_gen #(.POLY(8'h1D), .RC_INIT(8'h01)) dut_b (
      .clk(clk), .rst(rst), .start(start), .key_len(key_len), .next(next), .prev(prev),
      .rc_out(rc_b), .rc_idx(idx_b), .valid(valid_b), .last(last_b), .done(done_b)
   );

   typedef struct {
      logic [7:0] rca;
      logic [7:0] rcb;
      logic [3:0] idx;
      logic       v;
      logic       l;
      logic       d;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   vectors = 0;
   int   miscompares = 0;

   // Hand-computed constant sequences, index 1..10.
   logic [7:0] seqa [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
   logic [7:0] seqb [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D, 8'h3A};

   task automatic chk(input string name, input int vec, input logic [7:0] got,
                      input logic [7:0] want);
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s vec%0d: got %h want %h", name, vec, got, want);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            chk("rc_a",    vectors, rc_a, e.rca);
            chk("rc_b",    vectors, rc_b, e.rcb);
            chk("idx_a",   vectors, {4'h0, idx_a}, {4'h0, e.idx});
            chk("idx_b",   vectors, {4'h0, idx_b}, {4'h0, e.idx});
            chk("valid_a", vectors, {7'h0, valid_a}, {7'h0, e.v});
            chk("valid_b", vectors, {7'h0, valid_b}, {7'h0, e.v});
            chk("last_a",  vectors, {7'h0, last_a}, {7'h0, e.l});
            chk("last_b",  vectors, {7'h0, last_b}, {7'h0, e.l});
            chk("done_a",  vectors, {7'h0, done_a}, {7'h0, e.d});
            chk("done_b",  vectors, {7'h0, done_b}, {7'h0, e.d});
         end
      end
   end

   // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
   task automatic apply(input logic r, input logic s, input logic [1:0] kl, input logic n,
                        input logic p, input logic [3:0] eidx, input logic ev,
                        input logic el, input logic ed);
      exp_t x;
      @(negedge clk);
      #1;
      rst     = r;
      start   = s;
      key_len = kl;
      next    = n;
      prev    = p;
      x.idx = eidx;
      x.rca = (eidx == 4'd0) ? 8'h00 : seqa[eidx - 4'd1];
      x.rcb = (eidx == 4'd0) ? 8'h00 : seqb[eidx - 4'd1];
      x.v   = ev;
      x.l   = el;
      x.d   = ed;
      q.push_back(x);
   endtask

   // next pulses from index 'from' to 'to' with latched length n; key_len driven to 00.
   task automatic walk(input int from, input int to, input int n);
      for (int i = from + 1; i <= to; i++)
         apply(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 4'(i), 1'b1, (i == n), 1'b0);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; key_len = 2'b00; next = 1'b0; prev = 1'b0;

      apply(1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
      apply(0, 0, 2'b00, 1, 0, 0, 0, 0, 0);
      apply(0, 0, 2'b00, 1, 1, 0, 0, 0, 0);

      // AES-128 full run, then DONE holds.
      apply(0, 1, 2'b00, 0, 0, 1, 1, 0, 0);
      walk(1, 10, 10);
      apply(0, 0, 2'b00, 1, 0, 10, 0, 0, 1);
      apply(0, 0, 2'b00, 1, 0, 10, 0, 0, 1);
      apply(0, 0, 2'b00, 0, 1, 10, 0, 0, 1);

      // AES-256; key_len changes after start must not matter.
      apply(0, 1, 2'b10, 0, 0, 1, 1, 0, 0);
      walk(1, 7, 7);
      apply(0, 0, 2'b00, 1, 0, 7, 0, 0, 1);

      // AES-192.
      apply(0, 1, 2'b01, 0, 0, 1, 1, 0, 0);
      walk(1, 8, 8);
      apply(0, 0, 2'b00, 1, 0, 8, 0, 0, 1);

      // key_len 11 behaves as AES-128.
      apply(0, 1, 2'b11, 0, 0, 1, 1, 0, 0);
      walk(1, 10, 10);
      apply(0, 0, 2'b00, 1, 0, 10, 0, 0, 1);

      // start wins over next mid-run; rst wins over next.
      apply(0, 1, 2'b00, 0, 0, 1, 1, 0, 0);
      walk(1, 5, 10);
      apply(0, 1, 2'b00, 1, 0, 1, 1, 0, 0);
      walk(1, 6, 10);
      apply(1, 0, 2'b00, 1, 0, 0, 0, 0, 0);
      apply(0, 0, 2'b00, 1, 0, 0, 0, 0, 0);

      // next+prev together holds; lone prev.
      apply(0, 1, 2'b00, 0, 0, 1, 1, 0, 0);
      walk(1, 3, 10);
      apply(0, 0, 2'b00, 1, 1, 3, 1, 0, 0);
`ifdef RCON_INVERSE_EN
      apply(0, 0, 2'b00, 0, 1, 2, 1, 0, 0);
      apply(0, 0, 2'b00, 1, 0, 3, 1, 0, 0);
      walk(3, 10, 10);
      for (int i = 9; i >= 1; i--)
         apply(0, 0, 2'b00, 0, 1, 4'(i), 1, 1'b0, 0);
      apply(0, 0, 2'b00, 0, 1, 1, 1, 0, 0);
      walk(1, 10, 10);
      apply(0, 0, 2'b00, 1, 0, 10, 0, 0, 1);
      apply(0, 0, 2'b00, 0, 1, 10, 0, 0, 1);
`else
      apply(0, 0, 2'b00, 0, 1, 3, 1, 0, 0);
      apply(0, 0, 2'b00, 1, 0, 4, 1, 0, 0);
`endif

      @(negedge clk);
      #1;
      rst = 1'b0; start = 1'b0; next = 1'b0; prev = 1'b0;
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
